// File: rtl/eff_sel_ctrl_if.sv
// Effect-selection controller bus.
// Groups the switch input, sample strobe and the controller outputs.
//   sw_i   : raw asynchronous switch word (W_SEL bits)
//   vld_i  : one-cycle sample strobe, one ramp step per pulse
//   sel_o  : registered effect-select word to the effects pipe
//   gain_o : fade gain 0..RAMP_LEN (GW bits)
//   busy_o : high while a fade/swap sequence is in progress
// Modports: master drives switches/strobe (board side), slave is the controller.
interface eff_sel_ctrl_if #(
  parameter int W_SEL    = 16,
  parameter int RAMP_LEN = 64
);
  localparam int GW = $clog2(RAMP_LEN) + 1;

  logic [W_SEL-1:0] sw_i;
  logic             vld_i;
  logic [W_SEL-1:0] sel_o;
  logic [GW-1:0]    gain_o;
  logic             busy_o;

  modport master (
    output sw_i,
    output vld_i,
    input  sel_o,
    input  gain_o,
    input  busy_o
  );

  modport slave (
    input  sw_i,
    input  vld_i,
    output sel_o,
    output gain_o,
    output busy_o
  );
endinterface

// File: rtl/eff_sel_ctrl.sv
// Effect-selection controller.
// Synchronizes and debounces the switch word; on an accepted change it fades
// the gain to zero (one step per vld_i), swaps the effect-select word while
// silent, then fades back up to full gain.
// Ports:
//   clk : master clock (only clock)
//   rst : synchronous active-high reset
//   bus : eff_sel_ctrl_if.slave (sw_i, vld_i in; sel_o, gain_o, busy_o out)
module eff_sel_ctrl #(
  parameter int W_SEL      = 16,
  parameter int DEB_CYCLES = 65536,
  parameter int RAMP_LEN   = 64
) (
  input  logic          clk,
  input  logic          rst,
  eff_sel_ctrl_if.slave bus
);
  localparam int GW = $clog2(RAMP_LEN) + 1;
  localparam int CW = $clog2(DEB_CYCLES);

  localparam logic [GW-1:0] GAIN_FULL = GW'(RAMP_LEN);
  localparam logic [GW-1:0] GAIN_ZERO = {GW{1'b0}};
  localparam logic [GW-1:0] GAIN_ONE  = GW'(1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FADE_OUT = 2'd1,
    ST_SWAP     = 2'd2,
    ST_FADE_IN  = 2'd3
  } state_e;

  logic [W_SEL-1:0] sync1_q, sync1_d;
  logic [W_SEL-1:0] sync2_q, sync2_d;
  logic [W_SEL-1:0] cand_q, cand_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W_SEL-1:0] stable_q, stable_d;
  state_e           state_q, state_d;
  logic [GW-1:0]    gain_q, gain_d;
  logic [W_SEL-1:0] sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             sel_diff_s;

  // Synchronizer shift and debounce: a word is accepted only after the
  // synchronized value has matched the candidate for DEB_CYCLES clocks.
  always_comb begin
    sync1_d  = bus.sw_i;
    sync2_d  = sync1_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = {CW{1'b0}};
    end else if (cnt_q == CNT_LAST) begin
      // Counter saturates; stable keeps tracking the settled candidate.
      stable_d = cand_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  assign sel_diff_s = (stable_q != sel_q);

  // Fade FSM next-state, gain ramp and select swap.
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    sel_d   = sel_q;
    case (state_q)
      ST_IDLE: begin
        gain_d = GAIN_FULL;
        if (sel_diff_s) begin
          state_d = ST_FADE_OUT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FADE_OUT: begin
        // Silence is reached when the registered gain is 0; this also covers
        // entering with gain already 0 (no vld_i needed).
        if (gain_q == GAIN_ZERO) begin
          state_d = ST_SWAP;
        end else if (bus.vld_i) begin
          gain_d = gain_q - GAIN_ONE;
        end else begin
          gain_d = gain_q;
        end
      end
      ST_SWAP: begin
        sel_d   = stable_q;
        gain_d  = GAIN_ZERO;
        state_d = ST_FADE_IN;
      end
      ST_FADE_IN: begin
        if (sel_diff_s) begin
          // Reverse direction from the current gain; a coincident strobe is
          // already a fade-out step.
          state_d = ST_FADE_OUT;
          if (bus.vld_i && (gain_q != GAIN_ZERO)) begin
            gain_d = gain_q - GAIN_ONE;
          end else begin
            gain_d = gain_q;
          end
        end else if (gain_q == GAIN_FULL) begin
          state_d = ST_IDLE;
        end else if (bus.vld_i) begin
          gain_d = gain_q + GAIN_ONE;
        end else begin
          gain_d = gain_q;
        end
      end
      default: begin
        // Unreachable encoding: recover through a silent soft start.
        state_d = ST_FADE_IN;
        gain_d  = GAIN_ZERO;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State registers with synchronous reset into a soft start (FADE_IN at gain 0).
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= {W_SEL{1'b0}};
      sync2_q  <= {W_SEL{1'b0}};
      cand_q   <= {W_SEL{1'b0}};
      cnt_q    <= {CW{1'b0}};
      stable_q <= {W_SEL{1'b0}};
      state_q  <= ST_FADE_IN;
      gain_q   <= GAIN_ZERO;
      sel_q    <= {W_SEL{1'b0}};
      busy_q   <= 1'b1;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      state_q  <= state_d;
      gain_q   <= gain_d;
      sel_q    <= sel_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.sel_o  = sel_q;
  assign bus.gain_o = gain_q;
  assign bus.busy_o = busy_q;
endmodule

// File: tb/tb_eff_sel_ctrl.sv
// Testbench for eff_sel_ctrl: directed scenarios then randomized switch
// activity, checked every cycle against a behavioural model via a scoreboard.
module tb_eff_sel_ctrl;
  localparam int W   = 16;
  localparam int DEB = 4;
  localparam int RL  = 4;

  localparam int M_IDLE = 0;
  localparam int M_OUT  = 1;
  localparam int M_SWAP = 2;
  localparam int M_IN   = 3;

  typedef struct packed {
    logic [W-1:0] sel;
    logic [2:0]   gain;
    logic         busy;
  } exp_t;

  logic clk;
  logic rst;
  bit   vld_rand;

  eff_sel_ctrl_if #(.W_SEL(W), .RAMP_LEN(RL)) bus ();

  eff_sel_ctrl #(.W_SEL(W), .DEB_CYCLES(DEB), .RAMP_LEN(RL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state (written only by the model process).
  bit   m_live = 1'b0;
  int   m_sync1, m_sync2, m_run_word, m_run, m_stable;
  int   m_mode, m_gain, m_sel;

  // Reference model: advance one clock from the pre-edge inputs, queue the expectation.
  always @(posedge clk) begin
    int n_stable, n_mode, n_gain, n_sel, sws;
    exp_t e;
    if (rst) begin
      m_live = 1'b1;
      m_sync1 = 0; m_sync2 = 0;
      m_run_word = 0; m_run = 1; m_stable = 0;
      m_mode = M_IN; m_gain = 0; m_sel = 0;
      e.sel = '0; e.gain = 3'd0; e.busy = 1'b1;
      exp_q.push_back(e);
    end else if (m_live) begin
      // Debounce as a run length: the synchronized word is accepted once it
      // has been seen on DEB+1 consecutive edges.
      sws = m_sync2;
      if (sws == m_run_word) begin
        if (m_run < 1000) m_run = m_run + 1;
      end else begin
        m_run_word = sws;
        m_run = 1;
      end
      n_stable = (m_run >= DEB + 1) ? m_run_word : m_stable;
      m_sync2 = m_sync1;
      m_sync1 = int'(bus.sw_i);

      n_mode = m_mode; n_gain = m_gain; n_sel = m_sel;
      case (m_mode)
        M_IDLE: begin
          n_gain = RL;
          if (m_stable != m_sel) n_mode = M_OUT;
        end
        M_OUT: begin
          if (m_gain == 0) n_mode = M_SWAP;
          else if (bus.vld_i) n_gain = m_gain - 1;
        end
        M_SWAP: begin
          n_sel = m_stable; n_gain = 0; n_mode = M_IN;
        end
        default: begin
          if (m_stable != m_sel) begin
            n_mode = M_OUT;
            if (bus.vld_i && m_gain > 0) n_gain = m_gain - 1;
          end else if (m_gain == RL) n_mode = M_IDLE;
          else if (bus.vld_i) n_gain = m_gain + 1;
        end
      endcase
      m_stable = n_stable; m_mode = n_mode; m_gain = n_gain; m_sel = n_sel;
      e.sel = W'(m_sel); e.gain = 3'(m_gain); e.busy = (m_mode != M_IDLE);
      exp_q.push_back(e);
    end
  end

  // Monitor: pop and compare on the falling edge, plus the silent-swap invariant.
  initial begin
    exp_t e;
    logic [W-1:0] prev_sel;
    bit prev_ok = 1'b0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (bus.sel_o !== e.sel || bus.gain_o !== e.gain || bus.busy_o !== e.busy) begin
          n_bad++;
          $display("FAIL outputs @%0t: got sel=%h gain=%0d busy=%0b, required sel=%h gain=%0d busy=%0b",
                   $time, bus.sel_o, bus.gain_o, bus.busy_o, e.sel, e.gain, e.busy);
        end
        if (prev_ok && bus.sel_o !== prev_sel) begin
          n_cmp++;
          if (bus.gain_o !== 3'd0) begin
            n_bad++;
            $display("FAIL sel_change_silent @%0t: gain=%0d when sel changed, required 0",
                     $time, bus.gain_o);
          end
        end
        prev_sel = bus.sel_o;
        prev_ok  = 1'b1;
      end
    end
  end

  // Sample strobe: every 8 clocks in directed phases, random in the random phase.
  initial begin
    int cyc = 0;
    bus.vld_i = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (vld_rand) bus.vld_i = ($urandom_range(0, 3) == 0);
      else          bus.vld_i = (cyc % 8 == 0);
    end
  end

  // Wait (bounded) until the model reaches a mode / gain / select; -1 means don't care.
  task automatic wait_model(input int mode, input int gain, input int sel,
                            input int budget, input string name);
    int n = 0;
    while (!(m_mode == mode && (gain < 0 || m_gain == gain) && (sel < 0 || m_sel == sel))
           && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_%s: condition not reached within %0d cycles", name, budget);
    end
  endtask

  // Stimulus sequence.
  initial begin
    vld_rand = 1'b0;
    rst = 1'b1;
    bus.sw_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Soft start after reset.
    wait_model(M_IDLE, RL, 0, 400, "soft_start");
    repeat (5) @(negedge clk);

    // Glitch of 3 clocks must be rejected.
    bus.sw_i = 16'h0001;
    repeat (3) @(negedge clk);
    bus.sw_i = 16'h0000;
    repeat (30) @(negedge clk);

    // Clean swap to 5.
    bus.sw_i = 16'h0005;
    wait_model(M_IDLE, RL, 5, 400, "clean_swap");

    // Change during FADE_OUT: 1 then 2 at gain 2.
    bus.sw_i = 16'h0001;
    wait_model(M_OUT, 2, -1, 400, "fo_gain2");
    bus.sw_i = 16'h0002;
    wait_model(M_IDLE, RL, 2, 400, "fo_change");

    // Change during FADE_IN: swap to 1, then 3 at gain 2.
    bus.sw_i = 16'h0001;
    wait_model(M_IN, 2, 1, 400, "fi_gain2");
    bus.sw_i = 16'h0003;
    wait_model(M_IDLE, RL, 3, 400, "fi_change");

    // Reset in the middle of a fade-out.
    bus.sw_i = 16'h0004;
    wait_model(M_OUT, 2, -1, 400, "rst_gain2");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_model(M_IDLE, RL, -1, 600, "rst_recover");

    // Randomized switch activity, strobes and occasional resets.
    vld_rand = 1'b1;
    for (int i = 0; i < 60; i++) begin
      bus.sw_i = W'($urandom_range(0, 7));
      repeat ($urandom_range(1, 40)) @(negedge clk);
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
    bus.sw_i = 16'h0006;
    wait_model(M_IDLE, RL, 6, 1000, "final_settle");
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
